// File: rtl/mc8051_ci_sequencer_pkg.sv
// Shared definitions for the mc8051 machine-cycle sequencer.
//   - phase_e        : phase encodings PH_S1..PH_S6 plus PH_HALT (single-step builds only)
//   - CI_STAGE_WIDTH : width of the machine-cycle index within an instruction
//   - CI_STAGE_MAX   : last legal machine-cycle index
//   - is_mem_phase() : true for the memory-access phases S1..S3 that wait on i_mem_rdy
package mc8051_ci_sequencer_pkg;

    localparam int CI_STAGE_WIDTH = 2;
    localparam logic [CI_STAGE_WIDTH-1:0] CI_STAGE_MAX = 2'b11;

    typedef enum logic [2:0] {
        PH_S1   = 3'd0,
        PH_S2   = 3'd1,
        PH_S3   = 3'd2,
        PH_S4   = 3'd3,
        PH_S5   = 3'd4,
        PH_S6   = 3'd5,
        PH_HALT = 3'd6
    } phase_e;

    function automatic logic is_mem_phase(input phase_e ph);
        return (ph == PH_S1) || (ph == PH_S2) || (ph == PH_S3);
    endfunction

endpackage

// File: rtl/mc8051_ci_sequencer_if.sv
// Bus between the machine-cycle sequencer and its environment (program memory,
// microcode ROM, opcode decoder).
//   master modport : sequencer side (drives instr buffer, stage, fetch, ticks, error)
//   slave modport  : environment side (drives mem ready, ROM data, microcode continue bit)
// Optional macro MC8051_SINGLE_STEP_EN adds i_dbg_halt / i_dbg_step / o_dbg_halted.
interface mc8051_ci_sequencer_if;
    import mc8051_ci_sequencer_pkg::*;

    logic                      i_mem_rdy;
    logic [7:0]                i_rom_data;
    logic                      i_mc_more;
    logic [7:0]                o_instr_buffer;
    logic [CI_STAGE_WIDTH-1:0] o_ci_stage;
    logic                      o_op_fetch;
    logic                      o_s1_done_tick;
    logic                      o_s2_done_tick;
    logic                      o_s3_done_tick;
    logic                      o_s6_done_tick;
    logic                      o_instr_done;
    logic                      o_seq_err;
`ifdef MC8051_SINGLE_STEP_EN
    logic                      i_dbg_halt;
    logic                      i_dbg_step;
    logic                      o_dbg_halted;

    modport master (
        input  i_mem_rdy, i_rom_data, i_mc_more, i_dbg_halt, i_dbg_step,
        output o_instr_buffer, o_ci_stage, o_op_fetch, o_s1_done_tick, o_s2_done_tick,
               o_s3_done_tick, o_s6_done_tick, o_instr_done, o_seq_err, o_dbg_halted
    );
    modport slave (
        output i_mem_rdy, i_rom_data, i_mc_more, i_dbg_halt, i_dbg_step,
        input  o_instr_buffer, o_ci_stage, o_op_fetch, o_s1_done_tick, o_s2_done_tick,
               o_s3_done_tick, o_s6_done_tick, o_instr_done, o_seq_err, o_dbg_halted
    );
`else
    modport master (
        input  i_mem_rdy, i_rom_data, i_mc_more,
        output o_instr_buffer, o_ci_stage, o_op_fetch, o_s1_done_tick, o_s2_done_tick,
               o_s3_done_tick, o_s6_done_tick, o_instr_done, o_seq_err
    );
    modport slave (
        output i_mem_rdy, i_rom_data, i_mc_more,
        input  o_instr_buffer, o_ci_stage, o_op_fetch, o_s1_done_tick, o_s2_done_tick,
               o_s3_done_tick, o_s6_done_tick, o_instr_done, o_seq_err
    );
`endif

endinterface

// File: rtl/mc8051_ci_sequencer_stall_timer.sv
// Stall timer: counts consecutive not-ready cycles inside one memory phase.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : phase advanced or not in a memory phase -> count back to zero
//   en         : current cycle is a not-ready memory-phase cycle
//   tc         : this cycle is the STALL_LIMIT-th consecutive not-ready cycle
module mc8051_stall_timer #(
    parameter int STALL_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VALUE = 8'(STALL_LIMIT - 1);

    logic [7:0] count_r;

    // Consecutive stall cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Terminal count fires during the last allowed stall cycle so the phase advances on its edge.
    assign tc = en && (count_r == TC_VALUE);

endmodule

// File: rtl/mc8051_ci_sequencer.sv
// mc8051 machine-cycle sequencer: steps phases S1..S6 per machine cycle, owns the
// instruction buffer and ci_stage, emits S1/S2/S3/S6 done ticks and the instruction-done pulse.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (master)   : mem ready / ROM data / microcode continue in; buffer, stage, fetch,
//                    ticks, instr_done, sticky seq_err out
// Optional macro MC8051_SINGLE_STEP_EN: debug halt between instructions with single-step.
module mc8051_ci_sequencer
    import mc8051_ci_sequencer_pkg::*;
#(
    parameter logic [7:0] RST_OPCODE  = 8'h00,
    parameter int         STALL_LIMIT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    mc8051_ci_sequencer_if.master bus
);

    phase_e                    phase_r;
    phase_e                    phase_next_s;
    logic [CI_STAGE_WIDTH-1:0] stage_r;
    logic [7:0]                instr_buf_r;
    logic                      s1_tick_r, s2_tick_r, s3_tick_r, s6_tick_r;
    logic                      instr_done_r, seq_err_r;

    logic stall_en_s, stall_clr_s, stall_tc_s, mem_adv_s, instr_end_s;
    logic s1_set_s, s2_set_s, s3_set_s, s6_set_s, load_buf_s, ovf_s, op_fetch_s;

    // A memory phase advances on ready or, failing that, on stall timeout.
    assign stall_en_s  = is_mem_phase(phase_r) && !bus.i_mem_rdy;
    assign mem_adv_s   = is_mem_phase(phase_r) && (bus.i_mem_rdy || stall_tc_s);
    assign stall_clr_s = mem_adv_s || !is_mem_phase(phase_r);
    // Instruction ends unless microcode asks for another stage and one is left.
    assign instr_end_s = !(bus.i_mc_more && (stage_r != CI_STAGE_MAX));

    mc8051_stall_timer #(.STALL_LIMIT(STALL_LIMIT)) u_stall_timer (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (stall_clr_s),
        .en    (stall_en_s),
        .tc    (stall_tc_s)
    );

    // Phase state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phase_r <= PH_S1;
        end else begin
            phase_r <= phase_next_s;
        end
    end

    // Phase next-state logic.
    always_comb begin
        phase_next_s = phase_r;
        case (phase_r)
            PH_S1: begin
                if (mem_adv_s) phase_next_s = PH_S2;
                else           phase_next_s = PH_S1;
            end
            PH_S2: begin
                if (mem_adv_s) phase_next_s = PH_S3;
                else           phase_next_s = PH_S2;
            end
            PH_S3: begin
                if (mem_adv_s) phase_next_s = PH_S4;
                else           phase_next_s = PH_S3;
            end
            PH_S4: phase_next_s = PH_S5;
            PH_S5: phase_next_s = PH_S6;
`ifdef MC8051_SINGLE_STEP_EN
            PH_S6: begin
                if (instr_end_s && bus.i_dbg_halt) phase_next_s = PH_HALT;
                else                               phase_next_s = PH_S1;
            end
            PH_HALT: begin
                if (bus.i_dbg_step || !bus.i_dbg_halt) phase_next_s = PH_S1;
                else                                   phase_next_s = PH_HALT;
            end
`else
            PH_S6: phase_next_s = PH_S1;
`endif
            default: phase_next_s = PH_S1;
        endcase
    end

    // Output decode: which tick to raise, buffer load, error causes, fetch request.
    always_comb begin
        s1_set_s   = 1'b0;
        s2_set_s   = 1'b0;
        s3_set_s   = 1'b0;
        s6_set_s   = 1'b0;
        case (phase_r)
            PH_S1:   s1_set_s = mem_adv_s;
            PH_S2:   s2_set_s = mem_adv_s;
            PH_S3:   s3_set_s = mem_adv_s;
            PH_S6:   s6_set_s = 1'b1;
            default: s1_set_s = 1'b0;
        endcase
        load_buf_s = s1_set_s && (stage_r == 2'd0);
        ovf_s      = s6_set_s && bus.i_mc_more && (stage_r == CI_STAGE_MAX);
        op_fetch_s = (phase_r == PH_S1) && (stage_r == 2'd0);
    end

    // Stage counter, instruction buffer, ticks and sticky error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stage_r      <= 2'd0;
            instr_buf_r  <= RST_OPCODE;
            s1_tick_r    <= 1'b0;
            s2_tick_r    <= 1'b0;
            s3_tick_r    <= 1'b0;
            s6_tick_r    <= 1'b0;
            instr_done_r <= 1'b0;
            seq_err_r    <= 1'b0;
        end else begin
            s1_tick_r    <= s1_set_s;
            s2_tick_r    <= s2_set_s;
            s3_tick_r    <= s3_set_s;
            s6_tick_r    <= s6_set_s;
            instr_done_r <= s6_set_s && instr_end_s;
            if (s6_set_s) begin
                stage_r <= instr_end_s ? 2'd0 : stage_r + 2'd1;
            end else begin
                stage_r <= stage_r;
            end
            // A timed-out fetch never saw valid ROM data, so execute a NOP instead.
            if (load_buf_s) begin
                instr_buf_r <= stall_tc_s ? RST_OPCODE : bus.i_rom_data;
            end else begin
                instr_buf_r <= instr_buf_r;
            end
            seq_err_r <= seq_err_r || stall_tc_s || ovf_s;
        end
    end

    assign bus.o_instr_buffer = instr_buf_r;
    assign bus.o_ci_stage     = stage_r;
    assign bus.o_op_fetch     = op_fetch_s;
    assign bus.o_s1_done_tick = s1_tick_r;
    assign bus.o_s2_done_tick = s2_tick_r;
    assign bus.o_s3_done_tick = s3_tick_r;
    assign bus.o_s6_done_tick = s6_tick_r;
    assign bus.o_instr_done   = instr_done_r;
    assign bus.o_seq_err      = seq_err_r;
`ifdef MC8051_SINGLE_STEP_EN
    assign bus.o_dbg_halted   = (phase_r == PH_HALT);
`endif

endmodule

// File: tb/tb_mc8051_ci_sequencer.sv
// Self-checking bench for mc8051_ci_sequencer: expected tick events are queued as stimulus
// is driven and compared by a monitor as the sequencer emits them.
module tb_mc8051_ci_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 0=S1 1=S2 2=S3 3=S6
        logic [31:0] cyc;
        logic        done;
        logic [7:0]  buf_v;
        logic [1:0]  stage;
    } ev_t;

    ev_t exp_q[$];

    mc8051_ci_sequencer_if bus ();

    mc8051_ci_sequencer #(.RST_OPCODE(8'h00), .STALL_LIMIT(15)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input int c, input logic d,
                        input logic [7:0] b, input logic [1:0] s);
        ev_t e;
        e.kind = k; e.cyc = c; e.done = d; e.buf_v = b; e.stage = s;
        exp_q.push_back(e);
    endtask

    // One unstalled machine cycle starting after cycle base.
    task automatic push_mc(input int base, input logic [7:0] b, input logic [1:0] st,
                           input logic [1:0] st_after, input logic d);
        push(2'd0, base + 1, 1'b0, b, st);
        push(2'd1, base + 2, 1'b0, b, st);
        push(2'd2, base + 3, 1'b0, b, st);
        push(2'd3, base + 6, d, b, st_after);
    endtask

    // Advance to 1 time unit after the negedge at which cyc reaches c.
    task automatic step_to(input int c);
        do @(negedge clk); while (cyc < c);
        #1;
    endtask

    // Monitor: every tick / instr_done must match the head of the expectation queue.
    always @(negedge clk) begin
        int  n;
        ev_t obs;
        n = int'(bus.o_s1_done_tick) + int'(bus.o_s2_done_tick)
          + int'(bus.o_s3_done_tick) + int'(bus.o_s6_done_tick);
        if (n != 0 || bus.o_instr_done === 1'b1) begin
            chk("single_tick", 64'(n <= 1), 64'd1);
            obs.kind  = bus.o_s1_done_tick ? 2'd0 : bus.o_s2_done_tick ? 2'd1 :
                        bus.o_s3_done_tick ? 2'd2 : 2'd3;
            obs.cyc   = cyc;
            obs.done  = bus.o_instr_done;
            obs.buf_v = bus.o_instr_buffer;
            obs.stage = bus.o_ci_stage;
            chk("event_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("event", 64'(obs), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        int t;
        rst_n          = 1'b0;
        bus.i_mem_rdy  = 1'b0;
        bus.i_rom_data = 8'h00;
        bus.i_mc_more  = 1'b0;
`ifdef MC8051_SINGLE_STEP_EN
        bus.i_dbg_halt = 1'b0;
        bus.i_dbg_step = 1'b0;
`endif
        step_to(2);
        chk("reset_buf", 64'(bus.o_instr_buffer), 64'h00);
        chk("reset_stage", 64'(bus.o_ci_stage), 64'd0);
        chk("reset_ticks", 64'({bus.o_s1_done_tick, bus.o_s2_done_tick,
                                bus.o_s3_done_tick, bus.o_s6_done_tick, bus.o_instr_done}), 64'd0);
        chk("reset_err", 64'(bus.o_seq_err), 64'd0);
        chk("reset_fetch", 64'(bus.o_op_fetch), 64'd1);

        // A: single machine-cycle instruction 0x74.
        rst_n = 1'b1; bus.i_mem_rdy = 1'b1; bus.i_rom_data = 8'h74; bus.i_mc_more = 1'b0;
        t = cyc;
        push_mc(t, 8'h74, 2'd0, 2'd0, 1'b1);
        step_to(t + 1);
        chk("a_fetch_drop", 64'(bus.o_op_fetch), 64'd0);
        chk("a_buf", 64'(bus.o_instr_buffer), 64'h74);
        step_to(t + 6);
        chk("a_stage", 64'(bus.o_ci_stage), 64'd0);
        chk("a_drain", 64'(exp_q.size()), 64'd0);

        // B: two machine cycles for 0x88; ROM changes during stage 1 must not disturb buffer.
        t = cyc;
        bus.i_rom_data = 8'h88; bus.i_mc_more = 1'b1;
        push_mc(t, 8'h88, 2'd0, 2'd1, 1'b0);
        push_mc(t + 6, 8'h88, 2'd1, 2'd0, 1'b1);
        step_to(t + 1);
        bus.i_rom_data = 8'h55;
        step_to(t + 6);
        bus.i_mc_more = 1'b0;
        chk("b_stage1", 64'(bus.o_ci_stage), 64'd1);
        chk("b_fetch_stage1", 64'(bus.o_op_fetch), 64'd0);
        step_to(t + 12);
        chk("b_buf_held", 64'(bus.o_instr_buffer), 64'h88);
        chk("b_drain", 64'(exp_q.size()), 64'd0);

        // C: ready low for 3 cycles in S2.
        t = cyc;
        bus.i_rom_data = 8'hA5;
        push(2'd0, t + 1, 1'b0, 8'hA5, 2'd0);
        push(2'd1, t + 5, 1'b0, 8'hA5, 2'd0);
        push(2'd2, t + 6, 1'b0, 8'hA5, 2'd0);
        push(2'd3, t + 9, 1'b1, 8'hA5, 2'd0);
        step_to(t + 1);
        bus.i_mem_rdy = 1'b0;
        step_to(t + 4);
        bus.i_mem_rdy = 1'b1;
        step_to(t + 9);
        chk("c_no_err", 64'(bus.o_seq_err), 64'd0);
        chk("c_drain", 64'(exp_q.size()), 64'd0);

        // D: fetch stalls until timeout; NOP loaded, error sticks.
        t = cyc;
        bus.i_rom_data = 8'h77; bus.i_mem_rdy = 1'b0;
        push(2'd0, t + 15, 1'b0, 8'h00, 2'd0);
        push(2'd1, t + 16, 1'b0, 8'h00, 2'd0);
        push(2'd2, t + 17, 1'b0, 8'h00, 2'd0);
        push(2'd3, t + 20, 1'b1, 8'h00, 2'd0);
        step_to(t + 14);
        chk("d_err_before", 64'(bus.o_seq_err), 64'd0);
        step_to(t + 15);
        chk("d_err_set", 64'(bus.o_seq_err), 64'd1);
        chk("d_buf_nop", 64'(bus.o_instr_buffer), 64'h00);
        bus.i_mem_rdy = 1'b1;
        step_to(t + 20);
        chk("d_err_sticky", 64'(bus.o_seq_err), 64'd1);
        chk("d_drain", 64'(exp_q.size()), 64'd0);

        // F: reset during stage-1 S4 abandons the instruction.
        t = cyc;
        bus.i_rom_data = 8'h3C; bus.i_mc_more = 1'b1;
        push_mc(t, 8'h3C, 2'd0, 2'd1, 1'b0);
        push(2'd0, t + 7, 1'b0, 8'h3C, 2'd1);
        push(2'd1, t + 8, 1'b0, 8'h3C, 2'd1);
        push(2'd2, t + 9, 1'b0, 8'h3C, 2'd1);
        step_to(t + 9);
        rst_n = 1'b0;
        step_to(t + 10);
        chk("f_stage", 64'(bus.o_ci_stage), 64'd0);
        chk("f_buf", 64'(bus.o_instr_buffer), 64'h00);
        chk("f_done", 64'(bus.o_instr_done), 64'd0);
        chk("f_err_clr", 64'(bus.o_seq_err), 64'd0);
        chk("f_fetch", 64'(bus.o_op_fetch), 64'd1);
        chk("f_drain", 64'(exp_q.size()), 64'd0);

        // E: continue bit held for four S6 -> stage overflow.
        rst_n = 1'b1; bus.i_rom_data = 8'hE1; bus.i_mc_more = 1'b1;
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            push_mc(t + 6 * k, 8'hE1, 2'(k), (k == 3) ? 2'd0 : 2'(k + 1), k == 3);
        end
        step_to(t + 18);
        chk("e_err_before", 64'(bus.o_seq_err), 64'd0);
        chk("e_stage3", 64'(bus.o_ci_stage), 64'd3);
        step_to(t + 24);
        chk("e_err_ovf", 64'(bus.o_seq_err), 64'd1);
        chk("e_stage_wrap", 64'(bus.o_ci_stage), 64'd0);
        chk("e_drain", 64'(exp_q.size()), 64'd0);
        bus.i_mc_more = 1'b0;

`ifdef MC8051_SINGLE_STEP_EN
        // Halt after an instruction, then single-step exactly one more.
        t = cyc;
        bus.i_dbg_halt = 1'b1; bus.i_rom_data = 8'h12;
        push_mc(t, 8'h12, 2'd0, 2'd0, 1'b1);
        step_to(t + 6);
        chk("h_halted", 64'(bus.o_dbg_halted), 64'd1);
        step_to(t + 10);
        chk("h_still_halted", 64'(bus.o_dbg_halted), 64'd1);
        chk("h_no_fetch", 64'(bus.o_op_fetch), 64'd0);
        chk("h_drain", 64'(exp_q.size()), 64'd0);
        t = cyc;
        bus.i_dbg_step = 1'b1;
        push_mc(t + 1, 8'h12, 2'd0, 2'd0, 1'b1);
        step_to(t + 1);
        bus.i_dbg_step = 1'b0;
        step_to(t + 10);
        chk("h_rehalted", 64'(bus.o_dbg_halted), 64'd1);
        chk("h_step_drain", 64'(exp_q.size()), 64'd0);
        bus.i_dbg_halt = 1'b0;
        t = cyc;
        step_to(t + 1);
        chk("h_released", 64'(bus.o_dbg_halted), 64'd0);
        push_mc(t + 1, 8'h12, 2'd0, 2'd0, 1'b1);
        step_to(t + 7);
        chk("h_run_drain", 64'(exp_q.size()), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
